// File: rtl/lc3b_types.sv
// Shared LC-3b types: the 16-bit machine word and the memory arbiter state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_IF,
        SERVE_MEM,
        RESP_IF,
        RESP_MEM
    } lc3b_arb_state;

    localparam logic [1:0] BE_ALL = 2'b11;

endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates IF-stage reads and MEM-stage reads/writes onto one physical memory port.
// Define MEM_ARB_FAIR_EN to stop MEM from starving IF after STARVE_MAX consecutive grants.
module pipeline_mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  lc3b_word   if_memaddr,
    input  logic       if_memread,
    input  logic [1:0] if_mem_byte_enable,
    output lc3b_word   if_mem_rdata,
    output logic       if_mem_resp,
    input  lc3b_word   mem_memaddr,
    input  logic       mem_memread,
    input  logic       mem_memwrite,
    input  lc3b_word   mem_mem_wdata,
    input  logic [1:0] mem_mem_byte_enable,
    output lc3b_word   mem_mem_rdata,
    output logic       mem_mem_resp,
    output lc3b_word   pmem_address,
    output logic       pmem_read,
    output logic       pmem_write,
    output lc3b_word   pmem_wdata,
    output logic [1:0] pmem_byte_enable,
    input  lc3b_word   pmem_rdata,
    input  logic       pmem_resp
);

    lc3b_arb_state state_reg;
    lc3b_word      addr_reg;
    lc3b_word      wdata_reg;
    lc3b_word      if_rdata_reg;
    lc3b_word      mem_rdata_reg;
    logic [1:0]    be_reg;
    logic          read_reg;
    logic          write_reg;
    logic          if_resp_reg;
    logic          mem_resp_reg;

    logic mem_req;
    logic grant_mem;
    logic grant_if;

    assign mem_req = mem_memread | mem_memwrite;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_reg;
    logic             if_forced;

    assign if_forced = if_memread && (starve_reg == CNT_MAX);

    always_comb begin
        grant_mem = mem_req && !if_forced;
        grant_if  = if_memread && !grant_mem;
    end

    // Counts only MEM grants that overtook a waiting IF read; any break in the run clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (grant_if) begin
                starve_reg <= '0;
            end else if (grant_mem) begin
                if (!if_memread) begin
                    starve_reg <= '0;
                end else if (starve_reg != CNT_MAX) begin
                    starve_reg <= starve_reg + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        grant_mem = mem_req;
        grant_if  = if_memread && !mem_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            read_reg      <= 1'b0;
            write_reg     <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
            if_resp_reg   <= 1'b0;
            mem_resp_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_mem) begin
                        addr_reg  <= mem_memaddr;
                        wdata_reg <= mem_mem_wdata;
                        be_reg    <= mem_mem_byte_enable;
                        // A simultaneous read+write request is treated as a write.
                        write_reg <= mem_memwrite;
                        read_reg  <= !mem_memwrite;
                        state_reg <= SERVE_MEM;
                    end else if (grant_if) begin
                        addr_reg  <= if_memaddr;
                        wdata_reg <= '0;
                        be_reg    <= BE_ALL;
                        write_reg <= 1'b0;
                        read_reg  <= 1'b1;
                        state_reg <= SERVE_IF;
                    end
                end
                SERVE_IF: begin
                    if (pmem_resp) begin
                        if_rdata_reg <= pmem_rdata;
                        read_reg     <= 1'b0;
                        write_reg    <= 1'b0;
                        if_resp_reg  <= 1'b1;
                        state_reg    <= RESP_IF;
                    end
                end
                SERVE_MEM: begin
                    if (pmem_resp) begin
                        mem_rdata_reg <= pmem_rdata;
                        read_reg      <= 1'b0;
                        write_reg     <= 1'b0;
                        mem_resp_reg  <= 1'b1;
                        state_reg     <= RESP_MEM;
                    end
                end
                RESP_IF: begin
                    if_resp_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
                RESP_MEM: begin
                    mem_resp_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign pmem_address     = addr_reg;
    assign pmem_wdata       = wdata_reg;
    assign pmem_byte_enable = be_reg;
    assign pmem_read        = read_reg;
    assign pmem_write       = write_reg;
    assign if_mem_rdata     = if_rdata_reg;
    assign if_mem_resp      = if_resp_reg;
    assign mem_mem_rdata    = mem_rdata_reg;
    assign mem_mem_resp     = mem_resp_reg;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter; the starvation scenario adapts to MEM_ARB_FAIR_EN.
module tb_pipeline_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] if_memaddr;
    logic        if_memread;
    logic [1:0]  if_mem_byte_enable;
    logic [15:0] if_mem_rdata;
    logic        if_mem_resp;
    logic [15:0] mem_memaddr;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [15:0] mem_mem_wdata;
    logic [1:0]  mem_mem_byte_enable;
    logic [15:0] mem_mem_rdata;
    logic        mem_mem_resp;
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int n_compared;
    int n_mismatched;

    pipeline_mem_arbiter #(.STARVE_MAX(3)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_memaddr          (if_memaddr),
        .if_memread          (if_memread),
        .if_mem_byte_enable  (if_mem_byte_enable),
        .if_mem_rdata        (if_mem_rdata),
        .if_mem_resp         (if_mem_resp),
        .mem_memaddr         (mem_memaddr),
        .mem_memread         (mem_memread),
        .mem_memwrite        (mem_memwrite),
        .mem_mem_wdata       (mem_mem_wdata),
        .mem_mem_byte_enable (mem_mem_byte_enable),
        .mem_mem_rdata       (mem_mem_rdata),
        .mem_mem_resp        (mem_mem_resp),
        .pmem_address        (pmem_address),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_wdata          (pmem_wdata),
        .pmem_byte_enable    (pmem_byte_enable),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Acts as physical memory: waits for a strobe, checks it, holds it lat cycles, then responds.
    task automatic do_pmem(input string name, input logic exp_rd, input logic exp_wr,
                           input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                           input logic [1:0] exp_be, input int lat, input logic [15:0] rdata,
                           input logic drop_if);
        logic [19:0] exp_vec;
        logic [19:0] obs_vec;
        int waited;
        exp_vec = {exp_rd, exp_wr, exp_addr, exp_be};
        waited = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        n_compared++;
        if (!(pmem_read || pmem_write)) begin
            n_mismatched++;
            $display("FAIL %s strobe_timeout: no pmem strobe within 8 cycles", name);
            return;
        end
        if (drop_if) if_memread = 1'b0;
        obs_vec = {pmem_read, pmem_write, pmem_address, pmem_byte_enable};
        if (obs_vec !== exp_vec) begin
            n_mismatched++;
            $display("FAIL %s strobe: got rd=%b wr=%b addr=%h be=%b, expected rd=%b wr=%b addr=%h be=%b",
                     name, pmem_read, pmem_write, pmem_address, pmem_byte_enable,
                     exp_rd, exp_wr, exp_addr, exp_be);
        end
        if (exp_wr) begin
            n_compared++;
            if (pmem_wdata !== exp_wdata) begin
                n_mismatched++;
                $display("FAIL %s wdata: got %h expected %h", name, pmem_wdata, exp_wdata);
            end
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            n_compared++;
            obs_vec = {pmem_read, pmem_write, pmem_address, pmem_byte_enable};
            if (obs_vec !== exp_vec) begin
                n_mismatched++;
                $display("FAIL %s stable_cycle%0d: got %h expected %h", name, k, obs_vec, exp_vec);
            end
        end
        pmem_rdata = rdata;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = 16'hDEAD;
        $display("txn %s: rd=%b wr=%b addr=%h be=%b lat=%0d rdata=%h", name, exp_rd, exp_wr,
                 exp_addr, exp_be, lat, rdata);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_compared++;
        if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable, if_mem_resp,
             mem_mem_resp, if_mem_rdata, mem_mem_rdata} !== 70'h0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got rd=%b wr=%b addr=%h wd=%h be=%b ir=%b mr=%b ird=%h mrd=%h, expected all zero",
                     pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
                     if_mem_resp, mem_mem_resp, if_mem_rdata, mem_mem_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({pmem_read, pmem_write, if_mem_resp, mem_mem_resp} !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL idle_after_reset: got %b expected 0000",
                     {pmem_read, pmem_write, if_mem_resp, mem_mem_resp});
        end
        $display("txn reset: done");
    endtask

    task automatic test_if_read();
        if_memaddr = 16'h0040;
        if_memread = 1'b1;
        do_pmem("if_read", 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, 3, 16'h1234, 1'b0);
        n_compared++;
        if ({if_mem_resp, mem_mem_resp, if_mem_rdata, pmem_read, pmem_write} !== {2'b10, 16'h1234, 2'b00}) begin
            n_mismatched++;
            $display("FAIL if_read_resp: got ir=%b mr=%b rdata=%h rd=%b wr=%b, expected ir=1 mr=0 rdata=1234 rd=0 wr=0",
                     if_mem_resp, mem_mem_resp, if_mem_rdata, pmem_read, pmem_write);
        end
        if_memread = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({if_mem_resp, if_mem_rdata, pmem_read} !== {1'b0, 16'h1234, 1'b0}) begin
            n_mismatched++;
            $display("FAIL if_read_hold: got ir=%b rdata=%h rd=%b, expected ir=0 rdata=1234 rd=0",
                     if_mem_resp, if_mem_rdata, pmem_read);
        end
    endtask

    task automatic test_mem_read();
        mem_memaddr = 16'h0400;
        mem_mem_byte_enable = 2'b11;
        mem_memread = 1'b1;
        do_pmem("mem_read", 1'b1, 1'b0, 16'h0400, 16'h0000, 2'b11, 1, 16'hA5A5, 1'b0);
        n_compared++;
        if ({mem_mem_resp, if_mem_resp, mem_mem_rdata, if_mem_rdata} !== {2'b10, 16'hA5A5, 16'h1234}) begin
            n_mismatched++;
            $display("FAIL mem_read_resp: got mr=%b ir=%b mrd=%h ird=%h, expected mr=1 ir=0 mrd=a5a5 ird=1234",
                     mem_mem_resp, if_mem_resp, mem_mem_rdata, if_mem_rdata);
        end
        mem_memread = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        if_memaddr = 16'h0010;
        if_memread = 1'b1;
        mem_memaddr = 16'h0200;
        mem_mem_wdata = 16'hBEEF;
        mem_mem_byte_enable = 2'b01;
        mem_memwrite = 1'b1;
        do_pmem("prio_mem_write", 1'b0, 1'b1, 16'h0200, 16'hBEEF, 2'b01, 2, 16'h0000, 1'b0);
        n_compared++;
        if ({mem_mem_resp, if_mem_resp} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL prio_mem_resp: got mr=%b ir=%b expected mr=1 ir=0", mem_mem_resp, if_mem_resp);
        end
        mem_memwrite = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({pmem_read, pmem_write, mem_mem_resp, if_mem_resp} !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL prio_idle_gap: got %b expected 0000",
                     {pmem_read, pmem_write, mem_mem_resp, if_mem_resp});
        end
        do_pmem("prio_if_read", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, 1, 16'h5678, 1'b0);
        n_compared++;
        if ({if_mem_resp, if_mem_rdata} !== {1'b1, 16'h5678}) begin
            n_mismatched++;
            $display("FAIL prio_if_resp: got ir=%b rdata=%h expected ir=1 rdata=5678", if_mem_resp, if_mem_rdata);
        end
        if_memread = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_both_read_write();
        mem_memaddr = 16'h0300;
        mem_mem_wdata = 16'h1111;
        mem_mem_byte_enable = 2'b10;
        mem_memread = 1'b1;
        mem_memwrite = 1'b1;
        do_pmem("both_rw", 1'b0, 1'b1, 16'h0300, 16'h1111, 2'b10, 2, 16'h0000, 1'b0);
        n_compared++;
        if (mem_mem_resp !== 1'b1) begin
            n_mismatched++;
            $display("FAIL both_rw_resp: got %b expected 1", mem_mem_resp);
        end
        mem_memread = 1'b0;
        mem_memwrite = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_drop_if();
        logic extra;
        if_memaddr = 16'h0050;
        if_memread = 1'b1;
        do_pmem("drop_if", 1'b1, 1'b0, 16'h0050, 16'h0000, 2'b11, 2, 16'h7777, 1'b1);
        n_compared++;
        if ({if_mem_resp, if_mem_rdata} !== {1'b1, 16'h7777}) begin
            n_mismatched++;
            $display("FAIL drop_if_resp: got ir=%b rdata=%h expected ir=1 rdata=7777", if_mem_resp, if_mem_rdata);
        end
        extra = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            extra = extra | if_mem_resp | mem_mem_resp | pmem_read | pmem_write;
        end
        n_compared++;
        if (extra !== 1'b0) begin
            n_mismatched++;
            $display("FAIL drop_if_quiet: got activity=%b expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        logic extra;
        mem_memaddr = 16'h0700;
        mem_mem_wdata = 16'hCAFE;
        mem_mem_byte_enable = 2'b11;
        mem_memwrite = 1'b1;
        repeat (2) @(negedge clk);
        n_compared++;
        if (pmem_write !== 1'b1) begin
            n_mismatched++;
            $display("FAIL reset_mid_serve: got wr=%b expected 1", pmem_write);
        end
        #2;
        rst_n = 1'b0;
        mem_memwrite = 1'b0;
        #1;
        n_compared++;
        if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable, mem_mem_resp} !== 37'h0) begin
            n_mismatched++;
            $display("FAIL reset_mid_async: got rd=%b wr=%b addr=%h wd=%h be=%b mr=%b expected all zero",
                     pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable, mem_mem_resp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pmem_rdata = 16'h9999;
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        extra = 1'b0;
        for (int k = 0; k < 3; k++) begin
            extra = extra | if_mem_resp | mem_mem_resp | pmem_read | pmem_write;
            @(negedge clk);
        end
        n_compared++;
        if ({extra, mem_mem_rdata, if_mem_rdata} !== 33'h0) begin
            n_mismatched++;
            $display("FAIL stray_resp: got activity=%b mrd=%h ird=%h expected 0 0000 0000",
                     extra, mem_mem_rdata, if_mem_rdata);
        end
        $display("txn reset_mid: done");
    endtask

    task automatic test_starvation();
        logic exp_if;
        if_memaddr = 16'h0070;
        if_memread = 1'b1;
        mem_memaddr = 16'h0600;
        mem_mem_byte_enable = 2'b11;
        mem_memread = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FAIR_EN
            exp_if = (i == 3);
`else
            exp_if = 1'b0;
`endif
            if (exp_if)
                do_pmem("starve_if", 1'b1, 1'b0, 16'h0070, 16'h0000, 2'b11, 1, 16'h0F0F, 1'b0);
            else
                do_pmem("starve_mem", 1'b1, 1'b0, 16'h0600, 16'h0000, 2'b11, 1, 16'h00A0 + 16'(i), 1'b0);
            n_compared++;
            if ({if_mem_resp, mem_mem_resp} !== {exp_if, !exp_if}) begin
                n_mismatched++;
                $display("FAIL starve_grant%0d: got ir=%b mr=%b expected ir=%b mr=%b",
                         i, if_mem_resp, mem_mem_resp, exp_if, !exp_if);
            end
            if (exp_if) if_memread = 1'b0;
        end
        mem_memread = 1'b0;
        if_memread = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        rst_n = 1'b0;
        if_memaddr = '0;
        if_memread = 1'b0;
        if_mem_byte_enable = 2'b00;
        mem_memaddr = '0;
        mem_memread = 1'b0;
        mem_memwrite = 1'b0;
        mem_mem_wdata = '0;
        mem_mem_byte_enable = 2'b00;
        pmem_rdata = '0;
        pmem_resp = 1'b0;

        test_reset();
        test_if_read();
        test_mem_read();
        test_priority();
        test_both_read_write();
        test_drop_if();
        test_reset_mid();
        test_starvation();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_mem_arbiter.md
PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_MAX, default 3, max consecutive MEM grants while IF waits (used only with MEM_ARB_FAIR_EN).
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_memaddr  in  16  IF read address (lc3b_word).
- if_memread  in  1  IF read request, held until if_mem_resp.
- if_mem_byte_enable  in  2  ignored for reads.
- if_mem_rdata  out  16  IF read data.
- if_mem_resp  out  1  IF completion pulse.
- mem_memaddr  in  16  MEM address.
- mem_memread  in  1  MEM read request.
- mem_memwrite  in  1  MEM write request.
- mem_mem_wdata  in  16  MEM write data.
- mem_mem_byte_enable  in  2  MEM byte lanes.
- mem_mem_rdata  out  16  MEM read data.
- mem_mem_resp  out  1  MEM completion pulse.
- pmem_address  out  16  physical memory address.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_wdata  out  16  physical write data.
- pmem_byte_enable  out  2  physical byte lanes.
- pmem_rdata  in  16  physical read data.
- pmem_resp  in  1  physical completion, one cycle.

Function
REQ-004 SHALL implement FSM states IDLE, SERVE_IF, SERVE_MEM, RESP_IF, RESP_MEM.
REQ-005 IDLE: pending MEM request -> SERVE_MEM; else pending if_memread -> SERVE_IF; else stay. MEM has fixed priority when MEM_ARB_FAIR_EN is undefined.
REQ-006 On entry to a SERVE state, SHALL register address, wdata, byte_enable and direction. pmem_* SHALL be driven from these registers and SHALL stay stable until pmem_resp.
REQ-007 SERVE_x: pmem_read or pmem_write held high. On pmem_resp, SHALL capture pmem_rdata into a data register and go to RESP_x.
REQ-008 RESP_x: SHALL assert x_resp for exactly one cycle with x_rdata equal to the captured data, drop pmem strobes, then go to IDLE.
REQ-009 Latency from request seen in IDLE to x_resp SHALL be pmem latency + 2 cycles; one idle cycle SHALL separate back-to-back transactions.
REQ-010 mem_memread and mem_memwrite asserted together SHALL be served as a write.
REQ-011 IF reads SHALL drive pmem_byte_enable = 2'b11.
REQ-012 Requests dropped during SERVE SHALL still complete; the resp pulse SHALL be issued regardless.
REQ-013 x_rdata SHALL hold its last captured value outside RESP (no glitch to pmem_rdata).
REQ-014 pmem_resp outside a SERVE state SHALL be ignored.

Reset
REQ-015 rst_n low SHALL immediately force IDLE. All strobes and resps SHALL be 0, data/address registers 16'h0000, and the starvation counter 0, including mid-transaction.
REQ-016 After reset release, the first arbitration SHALL occur in the first IDLE cycle.

Configuration
REQ-017 With MEM_ARB_FAIR_EN defined, SHALL count consecutive MEM grants while if_memread is pending. At count == STARVE_MAX, IF SHALL win the next IDLE arbitration and the counter SHALL clear; it SHALL also clear on any IF grant.
REQ-018 Without MEM_ARB_FAIR_EN, no counter logic SHALL exist and priority is strictly MEM-first.

Structure
REQ-019 The arbiter state enum type (lc3b_arb_state) SHALL be added to lc3b_types; lc3b_word SHALL be used for all 16-bit ports.
REQ-020 The block SHALL be a single module with no sub-module.

Verification
REQ-021 if_memread, addr 16'h0040, pmem_resp after 3 cycles, rdata 16'h1234 -> if_mem_resp one cycle later with 16'h1234, pmem_read low next cycle.
REQ-022 Simultaneous IF read 16'h0010 and MEM write 16'h0200 data 16'hBEEF be 2'b01 -> MEM served first with pmem_write, pmem_byte_enable 2'b01, then IF.
REQ-023 Reset pulse during SERVE_MEM -> strobes 0 immediately; stray pmem_resp after release produces no resp.
REQ-024 With MEM_ARB_FAIR_EN and STARVE_MAX=3, continuous MEM reads plus IF pending -> IF granted after the 3rd MEM transaction.
REQ-025 mem_memread and mem_memwrite both high -> pmem_write=1, pmem_read=0.
REQ-026 Requester drops if_memread mid-SERVE -> if_mem_resp still pulses once, FSM returns to IDLE.
